lynx_ioctl_loader: RTL and testbench
====================================

# lynx_ioctl_loader

Sink end of the HPS `ioctl` download stream for the Lynx48 core. It filters writes by `ioctl_index`, buffers accepted bytes in a small FIFO and replays them into a core memory port that may stall. When the buffer nears full it holds off the sender with `ioctl_wait`. It sits between the `ioctl_*` bus and the RAM/ROM arbiter, and reports load completion and error status to the core.

## Interface
Parameters:
- `INDEX`, 8'd1: `ioctl_index` value this loader accepts.
- `ADDR_W`, 16: memory address width.
- `BASE`, 16'h0000: offset added to `ioctl_addr`. The sum is truncated to `ADDR_W`.
- `DEPTH`, 4: FIFO entries. Power of two, at least 4.

Ports:
- `clk_sys`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `ioctl_download`, in, 1: a download session is active.
- `ioctl_wr`, in, 1: one-cycle byte strobe.
- `ioctl_addr`, in, 25: byte address within the file.
- `ioctl_dout`, in, 8: byte data.
- `ioctl_index`, in, 8: file/slot selector.
- `ioctl_wait`, out, 1: registered back-pressure to the sender.
- `mem_req`, out, 1: write request, held until acknowledged.
- `mem_ack`, in, 1: the write completes in any cycle where `mem_req` and `mem_ack` are both high.
- `mem_addr`, out, ADDR_W: write address.
- `mem_data`, out, 8: write data.
- `busy`, out, 1: high when the state is not IDLE.
- `done`, out, 1: one-cycle pulse when a load has fully drained.
- `byte_count`, out, 25: number of bytes accepted in the current or last session.
- `overflow`, out, 1: sticky. Set when a write is dropped because the FIFO is full.
- `range_err`, out, 1: sticky. Set when a write is dropped because it is out of range.

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE → LOAD: on a rising edge of `ioctl_download` (registered previous value was 0) while `ioctl_index==INDEX`. Entering LOAD clears `byte_count`, `overflow` and `range_err`.
- LOAD → DRAIN: when `ioctl_download` falls.
- DRAIN → DONE: when the FIFO is empty and `mem_req` is low.
- DONE → IDLE: unconditionally after one cycle. `done` is high only in DONE.
- Accept conditions: state is LOAD, `ioctl_wr`=1, `ioctl_index==INDEX`, and `ioctl_addr[24:ADDR_W]==0`.
  - If the FIFO is not full, push {`ioctl_addr[ADDR_W-1:0]+BASE`, `ioctl_dout`} and increment `byte_count` (wraps modulo 2^25).
  - If the FIFO is full, drop the byte and set `overflow`.
  - If the address is out of range, drop the byte and set `range_err`. It is not counted.
- Writes with a non-matching index, or outside LOAD, are ignored silently.
- The FIFO is show-ahead. `mem_req` = FIFO not empty. `mem_addr`/`mem_data` show the head entry and stay stable while `mem_req` is high and `mem_ack` is low.
  - `mem_req` & `mem_ack` pops the head.
- Push and pop in the same cycle: the count is unchanged, and a push into a full FIFO with a simultaneous pop is accepted.
- `ioctl_wait` next = (count after this cycle's push/pop) ≥ DEPTH-1. This leaves one slot of headroom for a strobe that is already in flight.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE, `ioctl_download` edge register 0.
- Latency: a byte accepted at cycle t appears on `mem_req`/`mem_addr`/`mem_data` at t+1 if it is the FIFO head.
- `ioctl_wait` is registered. It rises the cycle after the count reaches DEPTH-1 and falls the cycle after the count drops below DEPTH-1.
- `done` pulses exactly one cycle after the last ack of the drain. If the FIFO is already empty when `ioctl_download` falls: DRAIN lasts 1 cycle, and `done` asserts 2 cycles after the fall.
- Reset mid-LOAD or mid-DRAIN: the FIFO is flushed, pending writes are lost, and there is no `done` pulse.
  - If `ioctl_download` is still high when reset is released, it is ignored until it falls and rises again.
- A new rising `ioctl_download` during DRAIN or DONE is ignored.

## Structure
- Package `lynx_ioctl_pkg`: state enum `loader_state_t`; index constants `IDX_ROM=8'd0`, `IDX_TAP=8'd1`, `IDX_SNAP=8'd2`.
- Sub-module `ioctl_fifo`: a synchronous show-ahead FIFO parameterised on width and depth, with push/pop/full/empty/count outputs. It is reused by any future upload path.

## Test plan
- Single write: a session with `INDEX`=1 and one write addr 0x10, data 0xA5, with `mem_ack` tied high → `mem_req` high one cycle later with `mem_addr`=0x0010 and `mem_data`=0xA5; `byte_count`=1; after the download falls, `done` pulses once.
- Offset and range: `BASE`=0x4000, writes at 0x0000 and 0x1_0000 → memory receives address 0x4000; the second write is dropped, `range_err`=1, `byte_count`=1.
- Back-pressure: `mem_ack` held low, DEPTH=4, back-to-back writes → `ioctl_wait` is 1 on the cycle after the 3rd push. A 5th write while full is dropped with `overflow`=1. After `mem_ack` is released, 4 bytes are written in order.
- Index filter: a session with `ioctl_index`=0 and 3 writes → `busy` stays 0, no `mem_req`, `byte_count`=0.
- Simultaneous push and pop: with the FIFO full and `mem_ack`=1, write one byte → the byte is accepted, the count stays 4, and `overflow` stays 0.
- Reset mid-load: assert `reset` after 2 writes while `mem_ack`=0 → next cycle all outputs are 0 and the FIFO is empty. The remaining writes in the same session are ignored and no `done` pulse occurs.

Source files
------------

// File: rtl/lynx_ioctl_pkg.sv
// Shared types and constants for the Lynx48 ioctl download loader.
// Holds the loader state enum and the ioctl_index slot numbers.
package lynx_ioctl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } loader_state_t;

  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_TAP  = 8'd1;
  localparam logic [7:0] IDX_SNAP = 8'd2;

  localparam int IOCTL_AW = 25;

endpackage

// File: rtl/lynx_ioctl_loader_if.sv
// HPS ioctl byte stream plus the core memory write port.
// master: sender/memory side; slave: the loader.
interface lynx_ioctl_loader_if
  import lynx_ioctl_pkg::*;
#(
  parameter int ADDR_W = 16
);

  logic                ioctl_download;
  logic                ioctl_wr;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0]          ioctl_dout;
  logic [7:0]          ioctl_index;
  logic                ioctl_wait;

  logic                mem_req;
  logic                mem_ack;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_data;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr,
    output ioctl_dout, ioctl_index, mem_ack,
    input  ioctl_wait, mem_req, mem_addr, mem_data
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr,
    input  ioctl_dout, ioctl_index, mem_ack,
    output ioctl_wait, mem_req, mem_addr, mem_data
  );

endinterface

// File: rtl/ioctl_fifo.sv
// Synchronous show-ahead FIFO; rdata_o is the head entry.
// Ports: push/pop/wdata in, rdata/full/empty/count out.
module ioctl_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);

  localparam logic [AW-1:0] PONE  = AW'(1);
  localparam logic [AW:0]   CONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULLV = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == FULLV;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // A pop frees the slot, so a push into a full FIFO is taken too.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CONE;
      2'b01:   cnt_d = cnt_q - CONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PONE;
      if (do_pop)  rptr_q <= rptr_q + PONE;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lynx_ioctl_loader.sv
// ioctl download sink: filters by index, buffers bytes, replays to memory.
// Ports: clk_sys/reset, bus (ioctl + mem port), busy/done/count/errors.
module lynx_ioctl_loader
  import lynx_ioctl_pkg::*;
#(
  parameter logic [7:0]        INDEX  = IDX_TAP,
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter int                DEPTH  = 4
) (
  input  logic                clk_sys,
  input  logic                reset,
  lynx_ioctl_loader_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic [IOCTL_AW-1:0] byte_count,
  output logic                overflow,
  output logic                range_err
);

  localparam int EW = ADDR_W + 8;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] WAIT_LVL = CW'(DEPTH - 1);

  loader_state_t       state_q;
  logic                dl_q, blk_q, wait_q;
  logic                ovf_q, rerr_q;
  logic [IOCTL_AW-1:0] cnt_q;

  logic                rise, idx_ok, in_rng, acc;
  logic                push, pop, full, empty;
  logic [CW-1:0]       fcnt, fcnt_d;
  logic [ADDR_W-1:0]   waddr;
  logic [EW-1:0]       head;

  // blk_q masks a download still held high across reset.
  assign rise   = bus.ioctl_download & ~dl_q & ~blk_q;
  assign idx_ok = bus.ioctl_index == INDEX;
  assign in_rng = (bus.ioctl_addr >> ADDR_W) == '0;
  assign acc    = (state_q == S_LOAD) & bus.ioctl_wr & idx_ok;
  assign pop    = bus.mem_req & bus.mem_ack;
  assign push   = acc & in_rng & (~full | pop);
  assign waddr  = bus.ioctl_addr[ADDR_W-1:0] + BASE;

  ioctl_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({waddr, bus.ioctl_dout}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fcnt)
  );

  always_comb begin
    fcnt_d = fcnt;
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt + ONE;
      2'b01:   fcnt_d = fcnt - ONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      dl_q    <= 1'b0;
      blk_q   <= 1'b1;
      wait_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      dl_q <= bus.ioctl_download;
      if (!bus.ioctl_download) blk_q <= 1'b0;
      wait_q <= fcnt_d >= WAIT_LVL;
      if (push) cnt_q <= cnt_q + 25'd1;
      if (acc & in_rng & full & ~pop) ovf_q <= 1'b1;
      if (acc & ~in_rng) rerr_q <= 1'b1;
      unique case (state_q)
        S_IDLE: if (rise & idx_ok) begin
          state_q <= S_LOAD;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          rerr_q  <= 1'b0;
        end
        S_LOAD:  if (!bus.ioctl_download) state_q <= S_DRAIN;
        S_DRAIN: if (empty) state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Head is masked so the port reads zero when nothing is queued.
  assign bus.mem_req    = ~empty;
  assign {bus.mem_addr, bus.mem_data} = empty ? '0 : head;
  assign bus.ioctl_wait = wait_q;

  assign busy       = state_q != S_IDLE;
  assign done       = state_q == S_DONE;
  assign byte_count = cnt_q;
  assign overflow   = ovf_q;
  assign range_err  = rerr_q;

endmodule

// File: tb/tb_lynx_ioctl_loader.sv
// Self-checking bench for lynx_ioctl_loader.
// Scenario tasks plus a randomized queue-based reference model.
module tb_lynx_ioctl_loader;
  import lynx_ioctl_pkg::*;

  localparam int         AW    = 16;
  localparam int         DEPTH = 4;
  localparam logic [15:0] BASE = 16'h4000;
  localparam logic [7:0]  IDX  = IDX_TAP;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy, done, overflow, range_err;
  logic [24:0] byte_count;

  always #5 clk = ~clk;

  lynx_ioctl_loader_if #(.ADDR_W(AW)) bus ();

  lynx_ioctl_loader #(
    .INDEX(IDX), .ADDR_W(AW), .BASE(BASE), .DEPTH(DEPTH)
  ) dut (
    .clk_sys    (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count),
    .overflow   (overflow),
    .range_err  (range_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];

  // Record every completed memory write and every done cycle.
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ack)
      obs_q.push_back({bus.mem_addr, bus.mem_data});
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    bus.ioctl_index = IDX;
    bus.mem_ack = 1'b0;
  endtask

  task automatic start(input logic [7:0] idx);
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic wr1(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_wr = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    tick();
    bus.ioctl_wr = 1'b0;
  endtask

  function automatic logic [23:0] ent(input logic [24:0] a, input logic [7:0] d);
    logic [15:0] m;
    m = a[15:0] + BASE;
    return {m, d};
  endfunction

  task automatic test_reset();
    idle_bus();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({busy, done, overflow, range_err, bus.ioctl_wait, bus.mem_req} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, overflow, range_err, bus.ioctl_wait, bus.mem_req});
    end
    n_cmp++;
    if (byte_count !== 25'd0) begin
      n_bad++; $display("FAIL reset_count: got %0d want 0", byte_count);
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_data} !== 24'd0) begin
      n_bad++;
      $display("FAIL reset_mem: got %h want 000000", {bus.mem_addr, bus.mem_data});
    end
  endtask

  task automatic test_index();
    int d0;
    logic seen_busy, seen_req;
    d0 = done_cnt;
    seen_busy = 1'b0;
    seen_req = 1'b0;
    obs_q.delete();
    bus.mem_ack = 1'b1;
    start(IDX_ROM);
    for (int i = 0; i < 3; i++) begin
      wr1(25'(i), 8'($urandom));
      seen_busy |= busy;
      seen_req |= bus.mem_req;
    end
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_busy |= busy;
      seen_req |= bus.mem_req;
    end
    bus.ioctl_index = IDX;
    n_cmp++;
    if (seen_busy !== 1'b0) begin
      n_bad++; $display("FAIL index_busy: got %b want 0", seen_busy);
    end
    n_cmp++;
    if (seen_req !== 1'b0 || obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL index_req: got req %b writes %0d want 0 0", seen_req, obs_q.size());
    end
    n_cmp++;
    if (byte_count !== 25'd0 || done_cnt != d0) begin
      n_bad++;
      $display("FAIL index_count: got %0d done %0d want 0 0", byte_count, done_cnt - d0);
    end
  endtask

  task automatic test_single();
    int d0;
    obs_q.delete();
    bus.mem_ack = 1'b1;
    start(IDX);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL single_busy: got %b want 1", busy);
    end
    wr1(25'h10, 8'hA5);
    n_cmp++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_data} !== {1'b1, 16'h4010, 8'hA5}) begin
      n_bad++;
      $display("FAIL single_head: got %b %h %h want 1 4010 a5",
               bus.mem_req, bus.mem_addr, bus.mem_data);
    end
    n_cmp++;
    if (byte_count !== 25'd1) begin
      n_bad++; $display("FAIL single_count: got %0d want 1", byte_count);
    end
    tick();
    d0 = done_cnt;
    bus.ioctl_download = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_drain: got done %b busy %b want 0 1", done, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL single_done: got %b want 1", done);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt != d0 + 1) begin
      n_bad++;
      $display("FAIL single_end: got done %b busy %b pulses %0d want 0 0 1",
               done, busy, done_cnt - d0);
    end
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== 24'h4010A5) begin
      n_bad++;
      $display("FAIL single_write: got %0d writes want 1 of 4010a5", obs_q.size());
    end
  endtask

  task automatic test_range();
    int d0;
    obs_q.delete();
    d0 = done_cnt;
    bus.mem_ack = 1'b1;
    start(IDX);
    wr1(25'h0_0000, 8'h3C);
    wr1(25'h1_0000, 8'h77);
    tick();
    bus.ioctl_download = 1'b0;
    for (int k = 0; k < 20 && done_cnt == d0; k++) tick();
    n_cmp++;
    if (done_cnt != d0 + 1) begin
      n_bad++; $display("FAIL range_done: got %0d pulses want 1", done_cnt - d0);
    end
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== 24'h40003C) begin
      n_bad++; $display("FAIL range_write: got %0d writes want 1 of 40003c", obs_q.size());
    end
    n_cmp++;
    if ({range_err, overflow} !== 2'b10 || byte_count !== 25'd1) begin
      n_bad++;
      $display("FAIL range_flags: got rerr %b ovf %b cnt %0d want 1 0 1",
               range_err, overflow, byte_count);
    end
  endtask

  task automatic test_backpressure();
    int d0;
    logic [7:0] d;
    obs_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    bus.mem_ack = 1'b0;
    start(IDX);
    n_cmp++;
    if (range_err !== 1'b0) begin
      n_bad++; $display("FAIL bp_rerr_clear: got %b want 0", range_err);
    end
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      wr1(25'(8 * i + 3), d);
      if (i < DEPTH) exp_q.push_back(ent(25'(8 * i + 3), d));
      n_cmp++;
      if (bus.ioctl_wait !== (i >= 2)) begin
        n_bad++; $display("FAIL bp_wait%0d: got %b want %b", i, bus.ioctl_wait, i >= 2);
      end
      n_cmp++;
      if (overflow !== (i == 4)) begin
        n_bad++; $display("FAIL bp_ovf%0d: got %b want %b", i, overflow, i == 4);
      end
    end
    n_cmp++;
    if (byte_count !== 25'd4) begin
      n_bad++; $display("FAIL bp_count: got %0d want 4", byte_count);
    end
    bus.mem_ack = 1'b1;
    tick();
    n_cmp++;
    if (bus.ioctl_wait !== 1'b1) begin
      n_bad++; $display("FAIL bp_wait_hold: got %b want 1", bus.ioctl_wait);
    end
    tick();
    n_cmp++;
    if (bus.ioctl_wait !== 1'b0) begin
      n_bad++; $display("FAIL bp_wait_fall: got %b want 0", bus.ioctl_wait);
    end
    bus.ioctl_download = 1'b0;
    for (int k = 0; k < 20 && done_cnt == d0; k++) tick();
    n_cmp++;
    if (obs_q.size() != exp_q.size() || done_cnt != d0 + 1) begin
      n_bad++;
      $display("FAIL bp_drain: got %0d writes %0d pulses want %0d 1",
               obs_q.size(), done_cnt - d0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL bp_order%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_simul();
    int d0;
    logic [7:0] d;
    obs_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    bus.mem_ack = 1'b0;
    start(IDX);
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      if (i == 4) bus.mem_ack = 1'b1;
      wr1(25'(100 + i), d);
      exp_q.push_back(ent(25'(100 + i), d));
    end
    n_cmp++;
    if (byte_count !== 25'd5 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_accept: got cnt %0d ovf %b want 5 0", byte_count, overflow);
    end
    n_cmp++;
    if (bus.ioctl_wait !== 1'b1 || bus.mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL simul_full: got wait %b req %b want 1 1", bus.ioctl_wait, bus.mem_req);
    end
    bus.ioctl_download = 1'b0;
    for (int k = 0; k < 20 && done_cnt == d0; k++) tick();
    n_cmp++;
    if (obs_q.size() != 5 || done_cnt != d0 + 1) begin
      n_bad++;
      $display("FAIL simul_drain: got %0d writes %0d pulses want 5 1",
               obs_q.size(), done_cnt - d0);
    end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL simul_order%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    obs_q.delete();
    bus.mem_ack = 1'b0;
    start(IDX);
    wr1(25'h20, 8'h11);
    wr1(25'h21, 8'h22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d0 = done_cnt;
    n_cmp++;
    if ({busy, done, overflow, range_err, bus.ioctl_wait, bus.mem_req} !== 6'b0
        || byte_count !== 25'd0 || {bus.mem_addr, bus.mem_data} !== 24'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got flags %b cnt %0d mem %h want all 0",
               {busy, done, overflow, range_err, bus.ioctl_wait, bus.mem_req},
               byte_count, {bus.mem_addr, bus.mem_data});
    end
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr1(25'(i + 48), 8'(i + 7));
      n_cmp++;
      if (busy !== 1'b0 || bus.mem_req !== 1'b0 || byte_count !== 25'd0) begin
        n_bad++;
        $display("FAIL rstmid_ignore%0d: got busy %b req %b cnt %0d want 0 0 0",
                 i, busy, bus.mem_req, byte_count);
      end
    end
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (done_cnt != d0 || obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL rstmid_nodone: got %0d pulses %0d writes want 0 0",
               done_cnt - d0, obs_q.size());
    end
  endtask

  task automatic test_random();
    int d0, n_acc, occ;
    logic rerr_exp, acc, oor;
    logic [24:0] a;
    logic [7:0] d;
    for (int s = 0; s < 4; s++) begin
      obs_q.delete();
      exp_q.delete();
      n_acc = 0;
      rerr_exp = 1'b0;
      d0 = done_cnt;
      bus.mem_ack = 1'b0;
      start(IDX);
      for (int c = 0; c < 40; c++) begin
        bus.mem_ack = ($urandom_range(0, 3) != 0);
        bus.ioctl_index = IDX;
        acc = 1'b0;
        oor = 1'b0;
        if (!bus.ioctl_wait && $urandom_range(0, 2) != 0) begin
          int r;
          r = $urandom_range(0, 9);
          a = {9'd0, 16'($urandom)};
          d = 8'($urandom);
          if (r == 0) a = {9'($urandom_range(1, 511)), 16'($urandom)};
          if (r == 1) bus.ioctl_index = IDX_SNAP;
          oor = (r == 0);
          acc = (r >= 2);
          bus.ioctl_wr = 1'b1;
          bus.ioctl_addr = a;
          bus.ioctl_dout = d;
        end
        tick();
        bus.ioctl_wr = 1'b0;
        if (acc) begin
          exp_q.push_back(ent(a, d));
          n_acc++;
        end
        if (oor) rerr_exp = 1'b1;
        occ = n_acc - obs_q.size();
        n_cmp++;
        if (bus.mem_req !== (occ != 0) || bus.ioctl_wait !== (occ >= DEPTH - 1)) begin
          n_bad++;
          $display("FAIL rnd%0d_occ%0d: got req %b wait %b want %b %b (occ %0d)",
                   s, c, bus.mem_req, bus.ioctl_wait, occ != 0, occ >= DEPTH - 1, occ);
        end
      end
      bus.ioctl_index = IDX;
      bus.mem_ack = 1'b1;
      bus.ioctl_download = 1'b0;
      for (int k = 0; k < 30 && done_cnt == d0; k++) tick();
      tick();
      n_cmp++;
      if (done_cnt != d0 + 1 || obs_q.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL rnd%0d_drain: got %0d pulses %0d writes want 1 %0d",
                 s, done_cnt - d0, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL rnd%0d_w%0d: got %h want %h", s, i, obs_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (byte_count !== 25'(n_acc) || range_err !== rerr_exp || overflow !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd%0d_status: got cnt %0d rerr %b ovf %b want %0d %b 0",
                 s, byte_count, range_err, overflow, n_acc, rerr_exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_bus();
    test_reset();
    test_index();
    test_single();
    test_range();
    test_backpressure();
    test_simul();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
